// File: rtl/sdram_cpu_bridge.sv
// sdram_cpu_bridge: NES 6502 bus to sdram_nes_controller CPU port, UxROM PRG banking.
// Optional: define OPEN_BUS_EN for open-bus reads of $4020-$5FFF.
module sdram_cpu_bridge #(
  parameter int ADDR_DEPTH = 23,
  parameter int PRG_BANK_BITS = 3,
  parameter logic [ADDR_DEPTH-1:0] PRG_ROM_BASE = ADDR_DEPTH'(23'h000000),
  parameter logic [ADDR_DEPTH-1:0] PRG_RAM_BASE = ADDR_DEPTH'(23'h7E0000),
  parameter logic [ADDR_DEPTH-1:0] WRAM_BASE = ADDR_DEPTH'(23'h7F0000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync,
  input  logic                     rdy,
  input  logic [15:0]              cpu_a,
  input  logic                     cpu_rw,
  input  logic [7:0]               cpu_dout,
  output logic [7:0]               cpu_din,
  output logic                     io_sel,
  input  logic [7:0]               io_din,
  output logic [ADDR_DEPTH-1:0]    mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [7:0]               mem_data_wr,
  input  logic [7:0]               mem_data_rd,
  output logic [PRG_BANK_BITS-1:0] prg_bank
);

  typedef enum logic {WAIT_RDY, RUN} state_t;
  typedef enum logic [1:0] {P_NONE, P_MEM, P_IO, P_OB} pend_t;

  state_t state_q, state_d;
  pend_t  pend_q, pend_d;
  logic   cap, drop;

  logic [PRG_BANK_BITS-1:0] bank_sel;
  logic [ADDR_DEPTH-1:0]    dec_addr;
  logic                     dec_io, dec_rom, dec_ob;
  logic                     ret_en;
  logic [7:0]               ret_val;
  logic [7:0]               last_bus;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_RDY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cap = 1'b0;
    drop = 1'b0;
    unique case (state_q)
      WAIT_RDY: begin
        if (sync && rdy) begin
          state_d = RUN;
          cap = 1'b1;
        end
      end
      RUN: begin
        if (!rdy) begin
          state_d = WAIT_RDY;
          drop = 1'b1;
        end else begin
          cap = sync;
        end
      end
      default: state_d = WAIT_RDY;
    endcase
  end

`ifdef OPEN_BUS_EN
  assign dec_ob = (cpu_a[15:13] == 3'b010) && (|cpu_a[12:5]);
`else
  assign dec_ob = 1'b0;
`endif

  // $C000-$FFFF is pinned to the last bank
  assign bank_sel = cpu_a[14] ? '1 : prg_bank;

  always_comb begin
    dec_addr = '0;
    dec_io = 1'b0;
    dec_rom = 1'b0;
    unique case (1'b1)
      cpu_a[15]: begin
        dec_rom = 1'b1;
        dec_addr = PRG_ROM_BASE
                 + ADDR_DEPTH'({bank_sel, cpu_a[13:0]});
      end
      (cpu_a[15:13] == 3'b011):
        dec_addr = PRG_RAM_BASE + ADDR_DEPTH'(cpu_a[12:0]);
      (cpu_a[15:13] == 3'b000):
        dec_addr = WRAM_BASE + ADDR_DEPTH'(cpu_a[10:0]);
      default: dec_io = !dec_ob;
    endcase
  end

  always_comb begin
    ret_en = 1'b0;
    ret_val = cpu_din;
    unique case (pend_q)
      P_MEM: begin ret_en = cap; ret_val = mem_data_rd; end
      P_IO:  begin ret_en = cap; ret_val = io_din; end
      P_OB:  begin ret_en = cap; ret_val = last_bus; end
      default: ret_en = 1'b0;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (drop) begin
      pend_d = P_NONE;
    end else if (cap) begin
      unique case (1'b1)
        !cpu_rw: pend_d = P_NONE;
        dec_ob:  pend_d = P_OB;
        dec_io:  pend_d = P_IO;
        default: pend_d = P_MEM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= P_NONE;
      cpu_din     <= '0;
      io_sel      <= 1'b0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_data_wr <= '0;
      prg_bank    <= '0;
    end else begin
      pend_q <= pend_d;
      if (ret_en) cpu_din <= ret_val;
      if (drop) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
      end else if (cap) begin
        mem_addr <= dec_addr;
        io_sel   <= dec_io;
        mem_rd   <= cpu_rw && !dec_io && !dec_ob;
        mem_wr   <= !cpu_rw && !dec_io && !dec_ob && !dec_rom;
        if (!cpu_rw) mem_data_wr <= cpu_dout;
        if (!cpu_rw && dec_rom)
          prg_bank <= cpu_dout[PRG_BANK_BITS-1:0];
      end
    end
  end

`ifdef OPEN_BUS_EN
  // A write drives the bus after any data returned at the same sync
  always_ff @(posedge clk) begin
    if (rst)                  last_bus <= '0;
    else if (cap && !cpu_rw)  last_bus <= cpu_dout;
    else if (ret_en)          last_bus <= ret_val;
  end
`else
  assign last_bus = 8'h00;
`endif

endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// tb_sdram_cpu_bridge: directed scoreboard bench for sdram_cpu_bridge.
// Toy SDRAM model serves mem_rd/mem_wr; expected cpu_din values queue per read.
module tb_sdram_cpu_bridge;

  logic        clk = 1'b0;
  logic        rst, sync, rdy, cpu_rw;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout, cpu_din, io_din, mem_data_wr;
  logic [7:0]  mem_data_rd;
  logic        io_sel, mem_rd, mem_wr;
  logic [22:0] mem_addr;
  logic [2:0]  prg_bank;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem[bit [22:0]];

  always #5 clk = ~clk;

  sdram_cpu_bridge dut (
    .clk(clk), .rst(rst), .sync(sync), .rdy(rdy),
    .cpu_a(cpu_a), .cpu_rw(cpu_rw), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .io_sel(io_sel), .io_din(io_din),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd),
    .prg_bank(prg_bank)
  );

  always @(negedge clk) begin
    if (mem_wr) mem[mem_addr] = mem_data_wr;
    mem_data_rd = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic rw,
                      input logic [7:0] d);
    @(negedge clk);
    cpu_a = a; cpu_rw = rw; cpu_dout = d; sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic gap();
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, cpu_din, e);
    end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; rdy = 1'b0; cpu_rw = 1'b1;
    cpu_a = '0; cpu_dout = '0; io_din = 8'h80;
    mem[23'h014123] = 8'h5A;
    mem[23'h01C010] = 8'hC3;
    mem[23'h7E0000] = 8'h11;
    mem[23'h7E0001] = 8'h22;
    mem[23'h7E1000] = 8'h3C;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_din", cpu_din, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_prg_bank", prg_bank, 0);
    chk("rst_io_sel", io_sel, 0);
    chk("rst_mem_addr", mem_addr, 0);

    for (int i = 0; i < 5; i++) begin
      step(16'h0003, 1'b1, 8'h00);
      chk("wait_rdy_no_rd", mem_rd, 0);
      chk("wait_rdy_no_wr", mem_wr, 0);
      gap();
    end

    rdy = 1'b1;
    step(16'h0803, 1'b0, 8'hA5);
    chk("wr_wram_mem_wr", mem_wr, 1);
    chk("wr_wram_mem_rd", mem_rd, 0);
    chk("wr_wram_addr", mem_addr, 23'h7F0003);
    chk("wr_wram_data", mem_data_wr, 8'hA5);
    gap();

    step(16'h0003, 1'b1, 8'h00);
    chk("rd_wram_mem_rd", mem_rd, 1);
    chk("rd_wram_addr", mem_addr, 23'h7F0003);
    chk("hold_after_wr", cpu_din, 0);
    exp_q.push_back(8'hA5);
    gap();

    step(16'h8000, 1'b0, 8'h05);
    pop_chk("rd_wram_din");
    chk("bank_wr_no_mem_wr", mem_wr, 0);
    chk("bank_wr_prg_bank", prg_bank, 5);
    gap();

    step(16'h8123, 1'b1, 8'h00);
    chk("rd_bank_addr", mem_addr, 23'h014123);
    chk("rd_bank_mem_rd", mem_rd, 1);
    exp_q.push_back(8'h5A);
    gap();

    step(16'hC010, 1'b1, 8'h00);
    pop_chk("rd_bank_din");
    chk("rd_fixed_addr", mem_addr, 23'h01C010);
    exp_q.push_back(8'hC3);
    gap();

    step(16'h2002, 1'b1, 8'h00);
    pop_chk("rd_fixed_din");
    chk("io_rd_io_sel", io_sel, 1);
    chk("io_rd_mem_rd", mem_rd, 0);
    exp_q.push_back(8'h80);
    gap();

    step(16'h6000, 1'b1, 8'h00);
    pop_chk("io_rd_din");
    chk("prgram_addr", mem_addr, 23'h7E0000);
    chk("prgram_mem_rd", mem_rd, 1);
    chk("prgram_io_sel", io_sel, 0);
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy_drop_mem_rd", mem_rd, 0);
    gap();
    for (int i = 0; i < 2; i++) begin
      step(16'h6001, 1'b1, 8'h00);
      chk("rdy_low_din_hold", cpu_din, 8'h80);
      chk("rdy_low_no_rd", mem_rd, 0);
      gap();
    end

    rdy = 1'b1;
    step(16'h6001, 1'b1, 8'h00);
    chk("discard_din_hold", cpu_din, 8'h80);
    chk("resume_addr", mem_addr, 23'h7E0001);
    chk("resume_mem_rd", mem_rd, 1);
    exp_q.push_back(8'h22);
    gap();

`ifdef OPEN_BUS_EN
    step(16'h7000, 1'b1, 8'h00);
    pop_chk("resume_din");
    chk("ob_pre_addr", mem_addr, 23'h7E1000);
    exp_q.push_back(8'h3C);
    gap();
    io_din = 8'h99;
    step(16'h5000, 1'b1, 8'h00);
    pop_chk("ob_pre_din");
    chk("ob_io_sel", io_sel, 0);
    chk("ob_mem_rd", mem_rd, 0);
    exp_q.push_back(8'h3C);
    gap();
`else
    io_din = 8'h99;
    step(16'h5000, 1'b1, 8'h00);
    pop_chk("resume_din");
    chk("io5000_io_sel", io_sel, 1);
    chk("io5000_mem_rd", mem_rd, 0);
    exp_q.push_back(8'h99);
    gap();
`endif

    step(16'h0003, 1'b1, 8'h00);
    pop_chk("hi_io_din");
    chk("wram_io_sel", io_sel, 0);
    exp_q.push_back(8'hA5);
    gap();

    step(16'h0000, 1'b0, 8'h00);
    pop_chk("final_din");
    chk("rw_exclusive", mem_rd & mem_wr, 0);
    gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_cpu_bridge.md
Name: sdram_cpu_bridge

Overview:
Upstream adapter between the NES 6502 bus and the CPU port of sdram_nes_controller. Once per sync window it decodes the CPU address into an SDRAM address or the I/O region. It issues exactly one mem_rd/mem_wr request per window and returns read data to the CPU at the next window. It also holds a UxROM-style PRG bank register.

Parameters:
ADDR_DEPTH, 23, SDRAM byte-address width (matches the controller)
PRG_BANK_BITS, 3, width of the PRG bank register (8 x 16 KB banks)
PRG_ROM_BASE, 23'h000000, SDRAM base of PRG ROM
PRG_RAM_BASE, 23'h7E0000, SDRAM base of 8 KB PRG RAM
WRAM_BASE, 23'h7F0000, SDRAM base of 2 KB internal RAM

Ports:
clk  in  1  system clock
rst  in  1  reset
sync  in  1  one-clk pulse per CPU cycle; same pulse the controller uses
rdy  in  1  controller ready (initialisation complete)
cpu_a  in  16  CPU address, valid at sync
cpu_rw  in  1  1 = read, 0 = write, valid at sync
cpu_dout  in  8  CPU write data, valid at sync
cpu_din  out  8  read data to CPU
io_sel  out  1  current window targets $2000-$5FFF
io_din  in  8  read data from I/O devices
mem_addr  out  ADDR_DEPTH  to controller cpu_addr
mem_rd  out  1  to controller cpu_rd
mem_wr  out  1  to controller cpu_wr
mem_data_wr  out  8  to controller cpu_data_wr
mem_data_rd  in  8  from controller cpu_data_rd
prg_bank  out  PRG_BANK_BITS  current switchable bank

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, all outputs are 0, prg_bank = 0 and state = WAIT_RDY.
- States:
  - WAIT_RDY: mem_rd = mem_wr = 0. Moves to RUN on the first sync with rdy = 1, and that sync is processed as a RUN capture in the same cycle.
  - RUN: a capture occurs on every sync.
- Capture at sync: cpu_a, cpu_rw and cpu_dout are decoded. mem_addr, mem_rd, mem_wr, mem_data_wr and io_sel are registered and held constant until the next sync.
- Decode:
  - $0000-$1FFF: WRAM_BASE + a[10:0] (mirrored).
  - $2000-$5FFF: io_sel = 1; no memory request.
  - $6000-$7FFF: PRG_RAM_BASE + a[12:0].
  - $8000-$BFFF: PRG_ROM_BASE + {prg_bank, a[13:0]}.
  - $C000-$FFFF: PRG_ROM_BASE + {all-ones bank, a[13:0]}.
- Address arithmetic is zero-extended to ADDR_DEPTH; overflow wraps modulo 2^ADDR_DEPTH.
- Read: mem_rd = 1 for one window. At the next sync, cpu_din <= mem_data_rd.
- Write to RAM regions: mem_wr = 1 and mem_data_wr = cpu_dout.
- Write to $8000-$FFFF: prg_bank <= cpu_dout[PRG_BANK_BITS-1:0] at that sync. No mem_wr (ROM). The new bank applies from the next capture.
- I/O read: at the next sync, cpu_din <= io_din as sampled at that sync. I/O write: no memory effect.
- Data return latency: cpu_din updates exactly at the sync following the request's capture sync. It holds otherwise, including after writes.
- mem_rd and mem_wr are never high together. Each is high for at most one window per capture.
- rdy falls in RUN: in the next cycle mem_rd = mem_wr = 0 and state = WAIT_RDY. An outstanding read is discarded and cpu_din holds.
- Reset mid-window: the request is dropped immediately and the reset values apply.
- Syncs while in WAIT_RDY are ignored.

Optional Feature:
OPEN_BUS_EN.
- Defined: a read of $4020-$5FFF (unmapped) returns the last value driven on the data bus, i.e. the last cpu_din or last written cpu_dout, and ignores io_din. io_sel is 0 for that range.
- Undefined: the whole of $2000-$5FFF is I/O as decoded above.

Test Plan:
- Hold rdy = 0 for 5 syncs, then raise it -> no mem_rd/mem_wr before the rdy sync; the first capture happens on the first sync with rdy = 1.
- Write 0xA5 to $0803, then read $0003 -> mem_wr with mem_addr = 23'h7F0003, then mem_rd at the same address; cpu_din = 0xA5 one sync later.
- Write 0x05 to $8000, then read $8123 -> prg_bank = 5, no mem_wr, mem_addr = 23'h014123. A read of $C010 -> mem_addr = 23'h01C010.
- Read $2002 with io_din = 0x80 -> io_sel = 1, mem_rd = 0, cpu_din = 0x80 at the next sync.
- Drop rdy one cycle after a read capture of $6000 -> mem_rd deasserts the next cycle, cpu_din keeps its old value, and operation resumes after rdy returns.
- With OPEN_BUS_EN defined: read $7000 returning 0x3C, then read $5000 -> cpu_din = 0x3C and io_sel = 0.
